dsi_packet_disassembler: RTL and testbench

//  Receive-side DSI packet parser. Consumes the de-serialised, sync-stripped HS byte stream of one data lane.
//  It splits the stream into short and long packets, checks the header ECC and the payload CRC, and

---
 rtl/dsi_packet_disassembler.sv | 237 +++++++++++++++++++++++
 tb/tb_dsi_packet_disassembler.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_packet_disassembler.sv
// Receive-side DSI packet parser for one HS data lane.
// Splits the sync-stripped byte stream into short and long packets, checks the
// 6-bit header ECC and the CRC-16/CCITT payload checksum, and presents header
// fields and payload bytes to the link layer with one cycle of latency.
module dsi_packet_disassembler #(
  parameter logic [15:0] g_max_wcount = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_d_i,
  input  logic        rx_valid_i,
  input  logic        rx_active_i,
  output logic        p_hdr_valid_o,
  output logic        p_islong_o,
  output logic [1:0]  p_vc_o,
  output logic [5:0]  p_type_o,
  output logic [15:0] p_wcount_o,
  output logic [7:0]  p_data_o,
  output logic        p_dvalid_o,
  output logic        p_dlast_o,
  output logic        p_end_o,
  output logic        p_crc_ok_o,
  output logic        err_ecc_o,
  output logic        err_trunc_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  // Hamming parity of the 24-bit header {data1, data0, DI}; each mask selects
  // the header bits covered by one parity bit.
  function automatic logic [5:0] calc_ecc(input logic [23:0] hdr);
    logic [5:0] p;
    p[0] = ^(hdr & 24'hF12CB7);
    p[1] = ^(hdr & 24'hF2555B);
    p[2] = ^(hdr & 24'h749A6D);
    p[3] = ^(hdr & 24'hB8E38E);
    p[4] = ^(hdr & 24'hDF03F0);
    p[5] = ^(hdr & 24'hEFFC00);
    return p;
  endfunction

  // One byte of reflected CRC-16/CCITT (x^16+x^12+x^5+1), bit 0 first.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[15:1]} ^ 16'h8408;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

  // Long data types: low nibble 9 or C..F.
  function automatic logic is_long_type(input logic [5:0] dt);
    return (dt[3:0] == 4'h9) || (dt[3:0] >= 4'hC);
  endfunction

  state_t      state_r;
  logic [1:0]  hdr_cnt_r;
  logic [7:0]  di_r;
  logic [7:0]  d0_r;
  logic [7:0]  d1_r;
  logic [15:0] rem_r;
  logic [15:0] crc_r;
  logic [7:0]  crc_lsb_r;
  logic        crc_cnt_r;

  logic [15:0] wc_s;
  logic        hdr_long_s;
  logic        ecc_ok_s;
  logic        wc_big_s;

  // Header decode: the ECC byte is compared live against the captured header.
  always_comb begin
    wc_s       = {d1_r, d0_r};
    hdr_long_s = is_long_type(di_r[5:0]);
    ecc_ok_s   = (rx_d_i == {2'b00, calc_ecc({d1_r, d0_r, di_r})});
    wc_big_s   = ({1'b0, wc_s} > {1'b0, g_max_wcount});
  end

  // Packet parser FSM with registered pulse and field outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r       <= ST_IDLE;
      hdr_cnt_r     <= 2'd0;
      di_r          <= 8'h00;
      d0_r          <= 8'h00;
      d1_r          <= 8'h00;
      rem_r         <= 16'd0;
      crc_r         <= 16'hFFFF;
      crc_lsb_r     <= 8'h00;
      crc_cnt_r     <= 1'b0;
      p_hdr_valid_o <= 1'b0;
      p_islong_o    <= 1'b0;
      p_vc_o        <= 2'd0;
      p_type_o      <= 6'd0;
      p_wcount_o    <= 16'd0;
      p_data_o      <= 8'h00;
      p_dvalid_o    <= 1'b0;
      p_dlast_o     <= 1'b0;
      p_end_o       <= 1'b0;
      p_crc_ok_o    <= 1'b0;
      err_ecc_o     <= 1'b0;
      err_trunc_o   <= 1'b0;
    end else begin
      p_hdr_valid_o <= 1'b0;
      p_dvalid_o    <= 1'b0;
      p_dlast_o     <= 1'b0;
      p_end_o       <= 1'b0;
      p_crc_ok_o    <= 1'b0;
      err_ecc_o     <= 1'b0;
      err_trunc_o   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          crc_r <= 16'hFFFF;
          if (rx_active_i && rx_valid_i) begin
            di_r      <= rx_d_i;
            hdr_cnt_r <= 2'd1;
            state_r   <= ST_HEADER;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HEADER: begin
          if (!rx_active_i) begin
            err_trunc_o <= 1'b1;
            hdr_cnt_r   <= 2'd0;
            state_r     <= ST_IDLE;
          end else if (rx_valid_i) begin
            case (hdr_cnt_r)
              2'd1: begin
                d0_r      <= rx_d_i;
                hdr_cnt_r <= 2'd2;
              end
              2'd2: begin
                d1_r      <= rx_d_i;
                hdr_cnt_r <= 2'd3;
              end
              default: begin
                hdr_cnt_r <= 2'd0;
                if (!ecc_ok_s) begin
                  err_ecc_o <= 1'b1;
                  state_r   <= ST_DISCARD;
                end else if (hdr_long_s && wc_big_s) begin
                  err_trunc_o <= 1'b1;
                  state_r     <= ST_DISCARD;
                end else begin
                  p_hdr_valid_o <= 1'b1;
                  p_islong_o    <= hdr_long_s;
                  p_vc_o        <= di_r[7:6];
                  p_type_o      <= di_r[5:0];
                  p_wcount_o    <= wc_s;
                  if (!hdr_long_s) begin
                    state_r <= ST_IDLE;
                  end else if (wc_s == 16'd0) begin
                    crc_cnt_r <= 1'b0;
                    state_r   <= ST_CRC;
                  end else begin
                    rem_r   <= wc_s;
                    state_r <= ST_PAYLOAD;
                  end
                end
              end
            endcase
          end else begin
            state_r <= ST_HEADER;
          end
        end
        ST_PAYLOAD: begin
          if (!rx_active_i) begin
            err_trunc_o <= 1'b1;
            rem_r       <= 16'd0;
            state_r     <= ST_IDLE;
          end else if (rx_valid_i) begin
            p_data_o   <= rx_d_i;
            p_dvalid_o <= 1'b1;
            crc_r      <= crc_byte(crc_r, rx_d_i);
            if (rem_r != 16'd0) begin
              rem_r <= rem_r - 16'd1;
            end else begin
              rem_r <= 16'd0;
            end
            if (rem_r <= 16'd1) begin
              p_dlast_o <= 1'b1;
              crc_cnt_r <= 1'b0;
              state_r   <= ST_CRC;
            end else begin
              state_r <= ST_PAYLOAD;
            end
          end else begin
            state_r <= ST_PAYLOAD;
          end
        end
        ST_CRC: begin
          if (!rx_active_i) begin
            err_trunc_o <= 1'b1;
            crc_cnt_r   <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (rx_valid_i) begin
            if (!crc_cnt_r) begin
              crc_lsb_r <= rx_d_i;
              crc_cnt_r <= 1'b1;
            end else begin
              p_end_o    <= 1'b1;
              p_crc_ok_o <= ({rx_d_i, crc_lsb_r} == crc_r);
              crc_r      <= 16'hFFFF;
              crc_cnt_r  <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end else begin
            state_r <= ST_CRC;
          end
        end
        ST_DISCARD: begin
          if (!rx_active_i) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DISCARD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_disassembler.sv
// Self-checking bench for dsi_packet_disassembler: directed packet scenarios
// with hand-written expectations plus randomized bursts checked against a
// packet-level reference model.
module tb_dsi_packet_disassembler;

  localparam logic [15:0] MAX_WC   = 16'd40;
  localparam logic [31:0] EV_ECC   = 32'h4000_0000;
  localparam logic [31:0] EV_TRUNC = 32'h5000_0000;
  // Syndrome column of each header bit, bit 23 first.
  localparam logic [23:0][5:0] ECC_COL = {
    6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_d;
  logic        rx_valid;
  logic        rx_active;
  logic        p_hdr_valid, p_islong, p_dvalid, p_dlast, p_end, p_crc_ok, err_ecc, err_trunc;
  logic [1:0]  p_vc;
  logic [5:0]  p_type;
  logic [15:0] p_wcount;
  logic [7:0]  p_data;

  int checks = 0;
  int passes = 0;
  logic [7:0]  burst_q[$];
  logic [7:0]  pl_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [15:0] crc_tab [0:255];

  always #5 clk = ~clk;

  dsi_packet_disassembler #(.g_max_wcount(MAX_WC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_d_i(rx_d), .rx_valid_i(rx_valid), .rx_active_i(rx_active),
    .p_hdr_valid_o(p_hdr_valid), .p_islong_o(p_islong), .p_vc_o(p_vc), .p_type_o(p_type),
    .p_wcount_o(p_wcount), .p_data_o(p_data), .p_dvalid_o(p_dvalid), .p_dlast_o(p_dlast),
    .p_end_o(p_end), .p_crc_ok_o(p_crc_ok), .err_ecc_o(err_ecc), .err_trunc_o(err_trunc));

  function automatic logic [31:0] ev_hdr(input logic il, input logic [7:0] di, input logic [15:0] wc);
    return {4'h1, 3'b000, il, di, wc};
  endfunction
  function automatic logic [31:0] ev_data(input logic last, input logic [7:0] d);
    return {4'h2, 19'd0, last, d};
  endfunction
  function automatic logic [31:0] ev_end(input logic ok);
    return {4'h3, 27'd0, ok};
  endfunction

  function automatic logic [7:0] ref_ecc(input logic [23:0] h);
    logic [5:0] e;
    e = 6'd0;
    for (int i = 0; i < 24; i++) if (h[i]) e = e ^ ECC_COL[i];
    return {2'b00, e};
  endfunction
  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] b);
    return (crc >> 8) ^ crc_tab[crc[7:0] ^ b];
  endfunction
  function automatic logic tb_is_long(input logic [7:0] di);
    return (di[3:0] == 4'h9) || (di[3:0] >= 4'hC);
  endfunction

  // Event monitor: every output pulse becomes one entry in obs_q.
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_hdr_valid) obs_q.push_back(ev_hdr(p_islong, {p_vc, p_type}, p_wcount));
      if (p_dvalid)    obs_q.push_back(ev_data(p_dlast, p_data));
      if (p_end)       obs_q.push_back(ev_end(p_crc_ok));
      if (err_ecc)     obs_q.push_back(EV_ECC);
      if (err_trunc)   obs_q.push_back(EV_TRUNC);
    end
  end

  task automatic drive(input logic act, input logic vld, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_active = act;
    rx_valid  = vld;
    rx_d      = d;
  endtask

  task automatic send_burst(input logic bubbles, input logic valid_at_end);
    foreach (burst_q[k]) begin
      if (bubbles) repeat ($urandom_range(2, 0)) drive(1'b1, 1'b0, 8'($urandom));
      drive(1'b1, 1'b1, burst_q[k]);
    end
    drive(1'b0, valid_at_end, 8'($urandom));
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
  endtask

  task automatic fill_random(input int n);
    pl_q.delete();
    repeat (n) pl_q.push_back(8'($urandom));
  endtask

  task automatic add_pkt(input logic [7:0] di, input logic [15:0] wc, input logic bad_ecc, input int flip_idx);
    logic [15:0] crc;
    logic [7:0]  e;
    e = ref_ecc({wc, di});
    if (bad_ecc) e = e ^ 8'h04;
    burst_q.push_back(di);
    burst_q.push_back(wc[7:0]);
    burst_q.push_back(wc[15:8]);
    burst_q.push_back(e);
    if (tb_is_long(di)) begin
      crc = 16'hFFFF;
      for (int k = 0; k < int'(wc); k++) begin
        crc = ref_crc(crc, pl_q[k]);
        burst_q.push_back((k == flip_idx) ? (pl_q[k] ^ 8'h01) : pl_q[k]);
      end
      burst_q.push_back(crc[7:0]);
      burst_q.push_back(crc[15:8]);
    end
  endtask

  // Packet-level reference: walks the burst bytes and lists the expected events.
  task automatic model_burst;
    int i;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [15:0] crc;
    i = 0;
    while (i < burst_q.size()) begin
      if (burst_q.size() - i < 4) begin exp_q.push_back(EV_TRUNC); return; end
      di = burst_q[i];
      wc = {burst_q[i+2], burst_q[i+1]};
      if (burst_q[i+3] !== ref_ecc({wc, di})) begin exp_q.push_back(EV_ECC); return; end
      i += 4;
      if (!tb_is_long(di)) begin exp_q.push_back(ev_hdr(1'b0, di, wc)); continue; end
      if (wc > MAX_WC) begin exp_q.push_back(EV_TRUNC); return; end
      exp_q.push_back(ev_hdr(1'b1, di, wc));
      crc = 16'hFFFF;
      for (int k = 0; k < int'(wc); k++) begin
        if (i >= burst_q.size()) begin exp_q.push_back(EV_TRUNC); return; end
        exp_q.push_back(ev_data(k == int'(wc) - 1, burst_q[i]));
        crc = ref_crc(crc, burst_q[i]);
        i++;
      end
      if (burst_q.size() - i < 2) begin exp_q.push_back(EV_TRUNC); return; end
      exp_q.push_back(ev_end({burst_q[i+1], burst_q[i]} == crc));
      i += 2;
    end
  endtask

  task automatic start_case;
    burst_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({p_hdr_valid, p_islong, p_vc, p_type, p_wcount, p_data, p_dvalid, p_dlast, p_end, p_crc_ok, err_ecc, err_trunc} !== 40'd0)
      $display("FAIL reset_outputs: got %h, expected 0", {p_hdr_valid, p_islong, p_vc, p_type, p_wcount, p_data, p_dvalid, p_dlast, p_end, p_crc_ok, err_ecc, err_trunc});
    else passes++;
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({p_hdr_valid, p_dvalid, p_end, err_ecc, err_trunc} !== 5'd0)
      $display("FAIL idle_after_reset: got %b, expected 00000", {p_hdr_valid, p_dvalid, p_end, err_ecc, err_trunc});
    else passes++;
  endtask

  task automatic test_short_dcs;
    logic [31:0] got;
    start_case();
    add_pkt(8'h15, 16'h0029, 1'b0, -1);
    exp_q.push_back(ev_hdr(1'b0, 8'h15, 16'h0029));
    send_burst(1'b1, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL short_dcs count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL short_dcs event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  task automatic test_long;
    logic [31:0] got;
    start_case();
    pl_q = '{8'h2C, 8'h00, 8'hFF};
    add_pkt(8'h39, 16'd3, 1'b0, -1);
    exp_q = '{ev_hdr(1'b1, 8'h39, 16'd3), ev_data(1'b0, 8'h2C), ev_data(1'b0, 8'h00), ev_data(1'b1, 8'hFF), ev_end(1'b1)};
    send_burst(1'b1, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL long_pkt count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL long_pkt event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  task automatic test_crc_bad;
    logic [31:0] got;
    start_case();
    pl_q = '{8'h2C, 8'h00, 8'hFF};
    add_pkt(8'h39, 16'd3, 1'b0, 1);
    add_pkt(8'h05, 16'h2211, 1'b0, -1);
    exp_q = '{ev_hdr(1'b1, 8'h39, 16'd3), ev_data(1'b0, 8'h2C), ev_data(1'b0, 8'h01), ev_data(1'b1, 8'hFF),
              ev_end(1'b0), ev_hdr(1'b0, 8'h05, 16'h2211)};
    send_burst(1'b1, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL crc_bad count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL crc_bad event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  task automatic test_ecc_err;
    logic [31:0] got;
    start_case();
    add_pkt(8'h15, 16'h0029, 1'b1, -1);
    add_pkt(8'h05, 16'h2211, 1'b0, -1);
    exp_q.push_back(EV_ECC);
    send_burst(1'b1, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL ecc_err count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL ecc_err event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  // Bursts cut inside the payload, inside the header and inside the CRC.
  task automatic test_trunc;
    logic [31:0] got;
    for (int c = 0; c < 3; c++) begin
      start_case();
      if (c == 0) begin
        fill_random(8);
        add_pkt(8'h39, 16'd8, 1'b0, -1);
        burst_q = burst_q[0:7];
        exp_q.push_back(ev_hdr(1'b1, 8'h39, 16'd8));
        for (int k = 0; k < 4; k++) exp_q.push_back(ev_data(1'b0, pl_q[k]));
      end else if (c == 1) begin
        burst_q = '{8'h05, 8'h11};
      end else begin
        pl_q = '{8'hA5, 8'h5A};
        add_pkt(8'h1C, 16'd2, 1'b0, -1);
        burst_q = burst_q[0:6];
        exp_q = '{ev_hdr(1'b1, 8'h1C, 16'd2), ev_data(1'b0, 8'hA5), ev_data(1'b1, 8'h5A)};
      end
      exp_q.push_back(EV_TRUNC);
      send_burst(1'b1, 1'(c));
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL trunc%0d count: got %0d, expected %0d", c, obs_q.size(), exp_q.size());
      else passes++;
      for (int k = 0; k < exp_q.size(); k++) begin
        got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
        checks++;
        if (got !== exp_q[k]) $display("FAIL trunc%0d event %0d: got %h, expected %h", c, k, got, exp_q[k]);
        else passes++;
      end
    end
  endtask

  task automatic test_null;
    logic [31:0] got;
    start_case();
    burst_q = '{8'h09, 8'h00, 8'h00, ref_ecc(24'h000009), 8'hFF, 8'hFF};
    exp_q = '{ev_hdr(1'b1, 8'h09, 16'd0), ev_end(1'b1)};
    send_burst(1'b0, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL null_pkt count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL null_pkt event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  task automatic test_oversize;
    logic [31:0] got;
    start_case();
    fill_random(41);
    add_pkt(8'h29, 16'd41, 1'b0, -1);
    add_pkt(8'h05, 16'h2211, 1'b0, -1);
    exp_q.push_back(EV_TRUNC);
    send_burst(1'b1, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL oversize count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL oversize event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    start_case();
    add_pkt(8'h15, 16'h0029, 1'b0, -1);
    pl_q = '{8'h2C, 8'h00, 8'hFF};
    add_pkt(8'h79, 16'd3, 1'b0, -1);
    add_pkt(8'h09, 16'd0, 1'b0, -1);
    fill_random(5);
    add_pkt(8'hBE, 16'd5, 1'b0, -1);
    add_pkt(8'h45, 16'hBEEF, 1'b0, -1);
    model_burst();
    send_burst(1'b0, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL back_to_back count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL back_to_back event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  task automatic test_random;
    logic [31:0] got;
    logic [7:0]  di;
    logic [15:0] wc;
    int          cut;
    int          flip;
    for (int b = 0; b < 40; b++) begin
      start_case();
      repeat ($urandom_range(3, 1)) begin
        di = 8'($urandom);
        if (tb_is_long(di)) begin
          wc = ($urandom_range(9, 0) == 0) ? 16'($urandom_range(44, 41)) : 16'($urandom_range(10, 0));
          fill_random(int'(wc));
        end else begin
          wc = 16'($urandom);
        end
        flip = ($urandom_range(5, 0) == 0 && wc != 16'd0) ? int'($urandom_range(int'(wc) - 1, 0)) : -1;
        add_pkt(di, wc, $urandom_range(7, 0) == 0, flip);
      end
      if ($urandom_range(3, 0) == 0 && burst_q.size() > 1) begin
        cut = int'($urandom_range(burst_q.size() - 1, 1));
        burst_q = burst_q[0:cut-1];
      end
      model_burst();
      send_burst(1'b1, 1'($urandom_range(1, 0)));
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL random%0d count: got %0d, expected %0d", b, obs_q.size(), exp_q.size());
      else passes++;
      for (int k = 0; k < exp_q.size(); k++) begin
        got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
        checks++;
        if (got !== exp_q[k]) $display("FAIL random%0d event %0d: got %h, expected %h", b, k, got, exp_q[k]);
        else passes++;
      end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] got;
    start_case();
    fill_random(6);
    add_pkt(8'h39, 16'd6, 1'b0, -1);
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, burst_q[k]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    obs_q.delete();
    #1;
    checks++;
    if ({p_hdr_valid, p_islong, p_vc, p_type, p_wcount, p_data, p_dvalid, p_dlast, p_end, p_crc_ok, err_ecc, err_trunc} !== 40'd0)
      $display("FAIL async_reset_outputs: got %h, expected 0", {p_hdr_valid, p_islong, p_vc, p_type, p_wcount, p_data, p_dvalid, p_dlast, p_end, p_crc_ok, err_ecc, err_trunc});
    else passes++;
    rx_active = 1'b0;
    rx_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() !== 0) $display("FAIL async_reset_no_pulse: got %0d events, expected 0", obs_q.size());
    else passes++;
    start_case();
    add_pkt(8'h15, 16'h0029, 1'b0, -1);
    exp_q.push_back(ev_hdr(1'b0, 8'h15, 16'h0029));
    send_burst(1'b0, 1'b0);
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL after_reset count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 32'hFFFF_FFFF;
      checks++;
      if (got !== exp_q[k]) $display("FAIL after_reset event %0d: got %h, expected %h", k, got, exp_q[k]);
      else passes++;
    end
  endtask

  initial begin
    logic [15:0] c;
    rst_n     = 1'b0;
    rx_active = 1'b0;
    rx_valid  = 1'b0;
    rx_d      = 8'h00;
    for (int b = 0; b < 256; b++) begin
      c = 16'(b);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      crc_tab[b] = c;
    end
    test_reset();
    test_short_dcs();
    test_long();
    test_crc_bad();
    test_ecc_err();
    test_trunc();
    test_null();
    test_oversize();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still going at %0t, limit 500000", $time);
    $fatal(1);
  end

endmodule
